// File: rtl/pc_seq_pkg.sv
// Shared defaults and per-cycle operation decode for the program-counter sequencer.
package pc_seq_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int RESET_ADDR_DEF = 0;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_INC  = 3'd1,
    OP_JUMP = 3'd2,
    OP_CALL = 3'd3,
    OP_RET  = 3'd4,
    OP_ERR  = 3'd5
  } op_e;

  // Priority: stall > call/ret conflict > ret > call > jump > increment.
  function automatic op_e decode_op(input logic stall_i, input logic call_i,
                                    input logic ret_i, input logic load_i,
                                    input logic full_i, input logic empty_i);
    op_e op;
    if (stall_i) begin
      op = OP_HOLD;
    end else if (call_i && ret_i) begin
      op = OP_ERR;
    end else if (ret_i) begin
      if (empty_i) op = OP_ERR;
      else         op = OP_RET;
    end else if (call_i) begin
      if (full_i) op = OP_ERR;
      else        op = OP_CALL;
    end else if (load_i) begin
      op = OP_JUMP;
    end else begin
      op = OP_INC;
    end
    return op;
  endfunction

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// LIFO of return addresses; only the pointer is reset, entry contents are left as-is.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int SP_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]  sp_q;
  logic [SP_W-1:0]  sp_d;
  logic [SP_W-1:0]  top_idx_s;

  assign full_o  = (sp_q == SP_W'(DEPTH));
  assign empty_o = (sp_q == {SP_W{1'b0}});

  // Next pointer; overflow/underflow requests are refused here as well.
  always_comb begin
    sp_d = sp_q;
    if (push_i && !full_o) begin
      sp_d = sp_q + SP_W'(1);
    end else if (pop_i && !empty_o) begin
      sp_d = sp_q - SP_W'(1);
    end else begin
      sp_d = sp_q;
    end
  end

  // Top-of-stack read mux, decoded by loop to avoid index width mismatches.
  always_comb begin
    top_o = {WIDTH{1'b0}};
    if (empty_o) top_idx_s = {SP_W{1'b0}};
    else         top_idx_s = sp_q - SP_W'(1);
    for (int i = 0; i < DEPTH; i++) begin
      if (SP_W'(i) == top_idx_s) top_o = mem_q[i];
    end
  end

  // Stack pointer register.
  always_ff @(posedge clk) begin
    if (rst) sp_q <= {SP_W{1'b0}};
    else     sp_q <= sp_d;
  end

  // Entry storage write at the current pointer.
  always_ff @(posedge clk) begin
    if (!rst && push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (SP_W'(i) == sp_q) mem_q[i] <= push_data_i;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with jump, call/return and stall.
// Return stack is built only when PC_SEQUENCER_STACK_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = RESET_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              loadAddr,
  input  logic              call,
  input  logic              ret,
  input  logic [ADDR_W-1:0] inAddr,
  output logic [ADDR_W-1:0] addr,
  output logic              stackFull,
  output logic              stackEmpty,
  output logic              stackErr
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [ADDR_W-1:0] top_s;
  logic              call_s;
  logic              ret_s;
  logic              full_s;
  logic              empty_s;
  op_e               op_s;

  assign addr_inc_s = addr_q + ADDR_W'(1);
  assign op_s       = decode_op(stall, call_s, ret_s, loadAddr, full_s, empty_s);

`ifdef PC_SEQUENCER_STACK_EN
  logic err_q;
  logic err_d;

  assign call_s = call;
  assign ret_s  = ret;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (op_s == OP_CALL),
    .pop_i       (op_s == OP_RET),
    .push_data_i (addr_inc_s),
    .top_o       (top_s),
    .full_o      (full_s),
    .empty_o     (empty_s)
  );

  // Sticky error: only reset clears it.
  always_comb begin
    err_d = err_q;
    if (op_s == OP_ERR) err_d = 1'b1;
    else                err_d = err_q;
  end

  // Error flag register.
  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign stackErr = err_q;
`else
  logic unused_ctrl_s;

  assign unused_ctrl_s = call ^ ret;
  assign call_s        = 1'b0;
  assign ret_s         = 1'b0;
  assign top_s         = {ADDR_W{1'b0}};
  assign full_s        = 1'b0;
  assign empty_s       = 1'b1;
  assign stackErr      = 1'b0;
`endif

  // Next address selection.
  always_comb begin
    addr_d = addr_q;
    case (op_s)
      OP_HOLD: addr_d = addr_q;
      OP_INC:  addr_d = addr_inc_s;
      OP_JUMP: addr_d = inAddr;
      OP_CALL: addr_d = inAddr;
      OP_RET:  addr_d = top_s;
      OP_ERR:  addr_d = addr_inc_s;
      default: addr_d = addr_inc_s;
    endcase
  end

  // Program address register.
  always_ff @(posedge clk) begin
    if (rst) addr_q <= ADDR_W'(RESET_ADDR);
    else     addr_q <= addr_d;
  end

  assign addr       = addr_q;
  assign stackFull  = full_s;
  assign stackEmpty = empty_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer; follows PC_SEQUENCER_STACK_EN like the RTL.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst, stall, load_addr, call, ret;
  logic [7:0] in_addr, addr;
  logic       stack_full, stack_empty, stack_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       rst, stall, load, call, ret;
    logic [7:0] in_addr;
    logic [7:0] exp_addr;
    logic       exp_full, exp_empty, exp_err;
  } vec_t;

  vec_t vecs[64];
  int   n_vec = 0;

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_ADDR(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .loadAddr   (load_addr),
    .call       (call),
    .ret        (ret),
    .inAddr     (in_addr),
    .addr       (addr),
    .stackFull  (stack_full),
    .stackEmpty (stack_empty),
    .stackErr   (stack_err)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic l, input logic c,
                     input logic rt, input logic [7:0] ia, input logic [7:0] ea,
                     input logic ef, input logic ee, input logic er);
    vecs[n_vec] = '{r, s, l, c, rt, ia, ea, ef, ee, er};
    n_vec++;
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic l, input logic c,
                       input logic rt, input logic [7:0] ia);
    rst = r; stall = s; load_addr = l; call = c; ret = rt; in_addr = ia;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; load_addr = 1'b0; call = 1'b0; ret = 1'b0; in_addr = 8'h00;

`ifdef PC_SEQUENCER_STACK_EN
    //   rst   stall load  call  ret   in     addr   full  empty err
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd10, 8'd10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd40, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd41, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd11, 1'b0, 1'b1, 1'b0);
    // stall drops a pending call
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd20, 8'd20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd99, 8'd20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd99, 8'd20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd99, 8'd20, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd21, 1'b0, 1'b1, 1'b0);
    // five nested calls, call wins over loadAddr
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h40, 8'h40, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h60, 8'h60, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h70, 8'h61, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h51, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h41, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h31, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd22, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd23, 1'b0, 1'b1, 1'b1);
    // reset clears error; conflict; reset with stall and call
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd7,  8'd7,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd50, 8'd8,  1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd8,  1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd90, 8'd90, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd60, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1,  1'b0, 1'b1, 1'b0);
`else
    //   rst   stall load  call  ret   in     addr   full  empty err
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h50, 8'h10, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5,  8'd5,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd40, 8'd6,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'd7,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h30, 8'h30, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h60, 8'h60, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 8'h61, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 8'd0,  1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd1,  1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < n_vec; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].load, vecs[i].call, vecs[i].ret,
            vecs[i].in_addr);
      chk("addr",  i, addr,               vecs[i].exp_addr);
      chk("full",  i, {7'd0, stack_full},  {7'd0, vecs[i].exp_full});
      chk("empty", i, {7'd0, stack_empty}, {7'd0, vecs[i].exp_empty});
      chk("err",   i, {7'd0, stack_err},   {7'd0, vecs[i].exp_err});
    end

    // Long idle run after reset: address counts up and wraps FF->00 silently.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("wrap_rst", 0, addr, 8'd0);
    for (int i = 1; i <= 300; i++) begin
      logic [7:0] exp_a;
      exp_a = 8'(i);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk("wrap_addr", i, addr, exp_a);
      chk("wrap_err",  i, {7'd0, stack_err}, 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: ADDR_W, 8, program address width in bits (>=2).
REQ-002 Parameter: STACK_DEPTH, 4, return-address stack entries (>=1).
REQ-003 Parameter: RESET_ADDR, 0, address loaded on reset.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: stall  input  1  freeze all state this cycle.
REQ-007 Port: loadAddr  input  1  jump: next addr = inAddr.
REQ-008 Port: call  input  1  push addr+1, next addr = inAddr.
REQ-009 Port: ret  input  1  pop: next addr = top of stack.
REQ-010 Port: inAddr  input  ADDR_W  jump/call target.
REQ-011 Port: addr  output  ADDR_W  current program address, registered.
REQ-012 Port: stackFull  output  1  stack holds STACK_DEPTH entries.
REQ-013 Port: stackEmpty  output  1  stack holds zero entries.
REQ-014 Port: stackErr  output  1  sticky overflow/underflow/conflict flag.

Function
REQ-015 All controls sampled at rising clk; addr/stack/flags take new values at that same edge (1-cycle latency, no combinational input-to-output path).
REQ-016 Priority per cycle: rst > stall > (call&ret conflict) > ret > call > loadAddr > increment.
REQ-017 Increment: addr <= addr+1 modulo 2^ADDR_W; max address wraps to 0, no flag.
REQ-018 loadAddr alone: addr <= inAddr; stack unchanged.
REQ-019 call, not full: stack[sp] <= addr+1 (wrapped), sp <= sp+1, addr <= inAddr; loadAddr ignored.
REQ-020 call when stackFull: no push, addr <= addr+1, stackErr <= 1 (overflow).
REQ-021 ret, not empty: addr <= stack[sp-1], sp <= sp-1.
REQ-022 ret when stackEmpty: sp unchanged, addr <= addr+1, stackErr <= 1 (underflow).
REQ-023 call and ret same cycle: stack unchanged, addr <= addr+1, stackErr <= 1.
REQ-024 stall: addr, stack contents, sp, stackErr hold; call/ret/loadAddr that cycle dropped, not queued.
REQ-025 stackFull = (sp == STACK_DEPTH); stackEmpty = (sp == 0); both decoded from registered sp.
REQ-026 stackErr, once set, stays 1 until rst; no other clear.
REQ-027 Stack pointer width $clog2(STACK_DEPTH+1); entries ADDR_W bits.

Reset
REQ-028 rst high at rising edge: addr <= RESET_ADDR, sp <= 0, stackErr <= 0, regardless of stall or any control.
REQ-029 Reset mid-call/ret discards in-flight operation; stack entry contents need not be cleared.
REQ-030 After reset: stackEmpty=1, stackFull=0, stackErr=0; first non-stalled non-reset cycle advances normally.

Configuration
REQ-031 Macro PC_SEQUENCER_STACK_EN defined: return stack, call, ret, flags built per REQ-019..REQ-027.
REQ-032 Macro undefined: no stack storage; call and ret ignored (treated as deasserted, call does not jump); stackFull=0, stackEmpty=1, stackErr=0 constant.

Structure
REQ-033 Shared package pc_seq_pkg holds address-width default, reset-vector default and the per-cycle operation enum (OP_HOLD, OP_INC, OP_JUMP, OP_CALL, OP_RET, OP_ERR).
REQ-034 Stack implemented as sub-module return_stack (LIFO, push/pop/full/empty, synchronous reset of pointer only), instantiated only under PC_SEQUENCER_STACK_EN.

Verification (ADDR_W=8, STACK_DEPTH=4, RESET_ADDR=0, macro defined unless noted)
REQ-035 rst 1 cycle, then 300 idle cycles -> addr 0,1,...,255,0,...; wraps FF->00, stackErr stays 0.
REQ-036 At addr 10 call inAddr=40, at addr 41 ret -> addr 40, 41, 11; stackEmpty 1->0->1.
REQ-037 Five nested calls from empty -> 5th call: addr increments, stackFull=1, stackErr=1; four rets return in LIFO order; 5th ret increments addr.
REQ-038 stall high 3 cycles with call asserted at addr 20 -> addr holds 20, stack unchanged; after stall low, addr 21.
REQ-039 call+ret together at addr 7 -> addr 8, stackErr=1; then rst asserted alongside stall -> addr 0, stackErr 0, stackEmpty 1.
REQ-040 Macro undefined: call inAddr=40 at addr 5 -> addr 6; stackEmpty=1, stackErr=0 throughout.
